// File: rtl/gt_lane_bond.sv
// gt_lane_bond: multi-lane GT receive deskew on K28.5 markers.
// Define LANE_BOND_STAT_EN to add o_err_cnt (saturating skew-error count).
module gt_lane_bond #(
  parameter int LANES          = 4,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int ERR_LIMIT      = 4,
  parameter int SEARCH_TIMEOUT = 1024
) (
  input  logic                     i_sysclk,
  input  logic                     i_rst_n,
  input  logic [LANES-1:0]         i_rx_ByteAlign,
  input  logic [LANES-1:0]         i_rx_valid,
  input  logic [LANES*DATA_W-1:0]  i_rx_data,
  input  logic [LANES*DATA_W/8-1:0] i_rx_char,
  output logic [LANES*DATA_W-1:0]  o_data,
  output logic [LANES*DATA_W/8-1:0] o_char,
  output logic                     o_valid,
  output logic                     o_bonded,
  output logic                     o_skew_err
`ifdef LANE_BOND_STAT_EN
  ,
  output logic [15:0]              o_err_cnt
`endif
);

  localparam int CW = DATA_W / 8;
  localparam int EW = DATA_W + CW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int MW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_ALIGNED
  } state_t;

  state_t r_state, w_state_nxt;

  logic [EW-1:0]    r_mem [LANES][FIFO_DEPTH];
  logic [AW:0]      r_wp  [LANES];
  logic [AW:0]      r_rp  [LANES];
  logic [TW-1:0]    r_tmo;
  logic [MW-1:0]    r_mis;
  logic             r_valid;
  logic             r_skew;
  logic [LANES*DATA_W-1:0] r_data;
  logic [LANES*CW-1:0]     r_char;

  logic [EW-1:0]    w_head [LANES];
  logic [LANES-1:0] w_empty, w_full, w_mk, w_wr, w_pop;
  logic w_ba_lost, w_all_mk, w_apop, w_ovf;
  logic w_tmo, w_mis, w_lim, w_flush, w_skew;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_mk    = '0;
    w_wr    = '0;
    for (int k = 0; k < LANES; k++) begin
      w_head[k]  = r_mem[k][r_rp[k][AW-1:0]];
      w_empty[k] = (r_wp[k] == r_rp[k]);
      w_full[k]  = ((r_wp[k] - r_rp[k]) == (AW+1)'(FIFO_DEPTH));
      w_mk[k]    = !w_empty[k] && (w_head[k][7:0] == 8'hBC)
                   && w_head[k][DATA_W];
      w_wr[k]    = i_rx_valid[k] && (r_state != S_IDLE);
    end
  end

  assign w_ba_lost = !(&i_rx_ByteAlign) && (r_state != S_IDLE);
  assign w_all_mk  = &w_mk;
  assign w_apop    = (r_state == S_ALIGNED) && !(|w_empty);

  // SEARCH drops non-marker heads; ALIGNED pops all lanes or none
  always_comb begin
    w_pop = '0;
    if (r_state == S_SEARCH)
      w_pop = ~w_empty & ~w_mk;
    else if (r_state == S_ALIGNED)
      w_pop = {LANES{w_apop}};
  end

  assign w_ovf   = |(w_wr & w_full & ~w_pop);
  assign w_tmo   = (r_state == S_SEARCH)
                   && (r_tmo == TW'(SEARCH_TIMEOUT - 1));
  assign w_mis   = w_apop && (|w_mk) && !w_all_mk;
  assign w_lim   = w_mis && (r_mis == MW'(ERR_LIMIT - 1));
  assign w_flush = w_ba_lost || w_ovf || w_tmo || w_lim;
  assign w_skew  = !w_ba_lost && (w_ovf || w_tmo || w_mis);

  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (&i_rx_ByteAlign) w_state_nxt = S_SEARCH;
      S_SEARCH:
        if (w_ba_lost)
          w_state_nxt = S_IDLE;
        else if (!w_ovf && !w_tmo && w_all_mk)
          w_state_nxt = S_ALIGNED;
      S_ALIGNED:
        if (w_ba_lost)
          w_state_nxt = S_IDLE;
        else if (w_ovf || w_lim)
          w_state_nxt = S_SEARCH;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_bonded   = (r_state == S_ALIGNED);
    o_valid    = r_valid;
    o_skew_err = r_skew;
    o_data     = r_data;
    o_char     = r_char;
  end

  // Storage needs no reset; a flush only rewinds the pointers
  always_ff @(posedge i_sysclk) begin
    for (int k = 0; k < LANES; k++)
      if (w_wr[k])
        r_mem[k][r_wp[k][AW-1:0]] <=
          {i_rx_char[k*CW +: CW], i_rx_data[k*DATA_W +: DATA_W]};
  end

  always_ff @(posedge i_sysclk) begin
    for (int k = 0; k < LANES; k++) begin
      if (!i_rst_n || w_flush) begin
        r_wp[k] <= '0;
        r_rp[k] <= '0;
      end else begin
        if (w_wr[k])  r_wp[k] <= r_wp[k] + 1'b1;
        if (w_pop[k]) r_rp[k] <= r_rp[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) begin
      r_tmo   <= '0;
      r_mis   <= '0;
      r_valid <= 1'b0;
      r_skew  <= 1'b0;
      r_data  <= '0;
      r_char  <= '0;
    end else begin
      r_tmo  <= (r_state == S_SEARCH && !w_flush) ? r_tmo + 1'b1 : '0;
      r_skew <= w_skew;
      if (r_state != S_ALIGNED || w_flush)
        r_mis <= '0;
      else if (w_mis)
        r_mis <= r_mis + 1'b1;
      else if (w_apop && w_all_mk)
        r_mis <= '0;
      r_valid <= w_apop && !w_ba_lost;
      if (w_apop && !w_ba_lost)
        for (int k = 0; k < LANES; k++) begin
          r_data[k*DATA_W +: DATA_W] <= w_head[k][DATA_W-1:0];
          r_char[k*CW +: CW]         <= w_head[k][EW-1:DATA_W];
        end
    end
  end

`ifdef LANE_BOND_STAT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n)
      r_err_cnt <= '0;
    else if (w_skew && r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/gt_lane_bond.md
GT_LANE_BOND -- requirements
Module: gt_lane_bond

Interface
REQ-001 SHALL have parameter LANES, default 4, number of bonded GT receive lanes (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, per-lane data width; char width is DATA_W/8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, per-lane deskew FIFO depth (power of 2, >=4).
REQ-004 SHALL have parameter ERR_LIMIT, default 4, consecutive marker mismatches before rebond.
REQ-005 SHALL have parameter SEARCH_TIMEOUT, default 1024, cycles allowed in SEARCH before restart.
REQ-006 SHALL have port i_sysclk  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port i_rx_ByteAlign  in  LANES  per-lane byte-align status.
REQ-009 SHALL have port i_rx_valid  in  LANES  per-lane word valid.
REQ-010 SHALL have port i_rx_data  in  LANES*DATA_W  lane k at [k*DATA_W +: DATA_W].
REQ-011 SHALL have port i_rx_char  in  LANES*DATA_W/8  per-byte K flags, same lane packing.
REQ-012 SHALL have ports o_data, o_char (widths as inputs), o_valid 1  deskewed output words.
REQ-013 SHALL have ports o_bonded 1 (lanes aligned) and o_skew_err 1 (one-cycle error pulse).

Function
REQ-014 Marker SHALL be a lane word with byte0 == 8'hBC and char bit0 == 1 (K28.5).
REQ-015 Each lane SHALL own a FIFO; written when i_rx_valid[k]=1 and state != IDLE.
REQ-016 FSM states SHALL be IDLE, SEARCH, ALIGNED.
REQ-017 IDLE -> SEARCH SHALL occur when all i_rx_ByteAlign bits are 1.
REQ-018 Any i_rx_ByteAlign bit at 0 in SEARCH or ALIGNED SHALL flush all FIFOs and enter IDLE next cycle.
REQ-019 In SEARCH, a lane whose FIFO head is non-empty and not a marker SHALL pop (discard) that word; a lane whose head is a marker SHALL hold.
REQ-020 When every lane is non-empty with a marker at head, FSM SHALL enter ALIGNED next cycle with no pop that cycle.
REQ-021 In SEARCH, a timeout counter SHALL count cycles; at SEARCH_TIMEOUT-1 it SHALL flush all FIFOs, reset, stay in SEARCH and pulse o_skew_err.
REQ-022 In ALIGNED, all lanes SHALL pop together only when all FIFOs are non-empty; never partially.
REQ-023 o_data/o_char SHALL be registered from the popped heads; o_valid=1 exactly one cycle after each pop; o_valid=0 otherwise; o_data holds last value.
REQ-024 A pop in ALIGNED with markers on some but not all lanes SHALL increment a mismatch counter and pulse o_skew_err next cycle.
REQ-025 A pop with markers on all lanes SHALL clear the mismatch counter; pops with no markers leave it unchanged.
REQ-026 Mismatch counter reaching ERR_LIMIT SHALL flush all FIFOs, clear the counter, enter SEARCH.
REQ-027 A write to a full FIFO with no same-cycle pop on that lane SHALL be an overflow: flush all, enter SEARCH (from ALIGNED) or restart SEARCH, pulse o_skew_err; write to full with same-cycle pop SHALL succeed.
REQ-028 Flush SHALL discard the same-cycle write; ByteAlign loss takes priority over overflow, overflow over mismatch limit.
REQ-029 o_bonded SHALL be 1 exactly while state is ALIGNED.

Reset
REQ-030 On i_rst_n=0 at a clock edge: state IDLE, FIFOs empty, all counters 0, o_data/o_char/o_valid/o_bonded/o_skew_err 0.
REQ-031 Reset mid-operation SHALL discard all buffered data; no o_valid until a fresh bond completes.

Configuration
REQ-032 With LANE_BOND_STAT_EN defined: port o_err_cnt out 16, saturating count of o_skew_err pulses, cleared only by reset.
REQ-033 Without LANE_BOND_STAT_EN: port o_err_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-034 LANES=4, lane skews 0/1/2/3 cycles, marker every 16 words -> o_bonded=1, o_valid words carry markers on all 4 lanes in same output cycle.
REQ-035 Bonded, lane 2 shifted by 1 word for 4 marker periods -> four o_skew_err pulses, o_bonded falls after 4th, rebonds within next marker period.
REQ-036 Lane 1 i_rx_valid held 0 with others streaming -> lane FIFO full on others after 8 writes, overflow, o_skew_err pulse, state SEARCH.
REQ-037 No markers sent after ByteAlign -> o_skew_err pulse every 1024 cycles, o_bonded stays 0.
REQ-038 Drop i_rx_ByteAlign[3] while bonded -> o_bonded=0 next cycle, IDLE, o_valid=0; i_rst_n=0 mid-stream -> all outputs 0 next edge (o_err_cnt=0 with LANE_BOND_STAT_EN).
